mc_controller: RTL and testbench

- Multicycle control FSM that sequences the shared 32-bit MIPS-subset datapath: one ALU, one register file, one unified instruction/data memory port.
- Decodes op/funct from the instruction register.
- Drives the datapath mux selects and write enables, including memtoreg, regdst, regwrite and alucontrol.
- Stalls on a req/ready memory handshake, so each instruction takes 3–5 states plus any memory wait cycles.

---
 rtl/mc_controller_if.sv | 41 ++++
 rtl/mc_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath/memory (slave).
interface mc_controller_if #(
  parameter int unsigned OPW = 6,
  parameter int unsigned ACW = 3
);
  localparam int unsigned SW = 4;

  // Instruction fields, ALU flag and memory handshake from the datapath
  logic [OPW-1:0] op;
  logic [OPW-1:0] funct;
  logic           zero;
  logic           mem_ready;

  // Datapath selects, write enables and debug state from the controller
  logic           mem_req;
  logic           iord;
  logic           memwrite;
  logic           irwrite;
  logic           pcwrite;
  logic           memtoreg;
  logic           regdst;
  logic           regwrite;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     pcsrc;
  logic [ACW-1:0] alucontrol;
  logic           illegal;
  logic [SW-1:0]  state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM driving a shared ALU/regfile/memory datapath.
// Define MC_BNE_EN to add bne (op 000101) through state BNE=12.
module mc_controller #(
  parameter int unsigned OPW = 6,
  parameter int unsigned ACW = 3
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master ctrl
);
  localparam int unsigned SW = 4;

  typedef enum logic [SW-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_e;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
`ifdef MC_BNE_EN
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
`endif

  localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

  localparam logic [ACW-1:0] ALU_ADD = ACW'(3'b010);
  localparam logic [ACW-1:0] ALU_SUB = ACW'(3'b110);
  localparam logic [ACW-1:0] ALU_AND = ACW'(3'b000);
  localparam logic [ACW-1:0] ALU_OR  = ACW'(3'b001);
  localparam logic [ACW-1:0] ALU_SLT = ACW'(3'b111);

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_e         state_q;
  state_e         state_d;
  state_e         view_s;
  logic           funct_ok_c;
  logic [ACW-1:0] funct_alu_c;

  logic           mem_req_c;
  logic           iord_c;
  logic           memwrite_c;
  logic           irwrite_c;
  logic           pcwrite_c;
  logic           memtoreg_c;
  logic           regdst_c;
  logic           regwrite_c;
  logic           alusrca_c;
  logic [1:0]     alusrcb_c;
  logic [1:0]     pcsrc_c;
  logic [ACW-1:0] alucontrol_c;
  logic           illegal_c;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type funct decode
  always_comb begin
    funct_ok_c  = 1'b1;
    funct_alu_c = ALU_ADD;
    case (ctrl.funct)
      FN_ADD:  funct_alu_c = ALU_ADD;
      FN_SUB:  funct_alu_c = ALU_SUB;
      FN_AND:  funct_alu_c = ALU_AND;
      FN_OR:   funct_alu_c = ALU_OR;
      FN_SLT:  funct_alu_c = ALU_SLT;
      default: funct_ok_c  = 1'b0;
    endcase
  end

  // Next state and Moore outputs; while in reset the outputs show FETCH with enables off
  always_comb begin
    view_s       = reset ? S_FETCH : state_q;
    state_d      = S_FETCH;
    mem_req_c    = 1'b0;
    iord_c       = 1'b0;
    memwrite_c   = 1'b0;
    irwrite_c    = 1'b0;
    pcwrite_c    = 1'b0;
    memtoreg_c   = 1'b0;
    regdst_c     = 1'b0;
    regwrite_c   = 1'b0;
    alusrca_c    = 1'b0;
    alusrcb_c    = SRCB_RT;
    pcsrc_c      = PC_ALU;
    alucontrol_c = ALU_AND;
    illegal_c    = 1'b0;

    case (view_s)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alusrcb_c    = SRCB_FOUR;
        alucontrol_c = ALU_ADD;
        pcsrc_c      = PC_ALU;
        irwrite_c    = ctrl.mem_ready;
        pcwrite_c    = ctrl.mem_ready;
        state_d      = ctrl.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb_c    = SRCB_IMMSH;
        alucontrol_c = ALU_ADD;
        case (ctrl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_IMM;
        alucontrol_c = ALU_ADD;
        state_d      = (ctrl.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        state_d   = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c  = 1'b1;
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        state_d    = ctrl.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_RT;
        alucontrol_c = funct_alu_c;
        illegal_c    = ~funct_ok_c;
        state_d      = funct_ok_c ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        regdst_c   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQ: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_RT;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = PC_ALUOUT;
        pcwrite_c    = ctrl.zero;
      end
      S_ADDIEX: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_IMM;
        alucontrol_c = ALU_ADD;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
      end
      S_JUMP: begin
        pcsrc_c   = PC_JUMP;
        pcwrite_c = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        alusrca_c    = 1'b1;
        alusrcb_c    = SRCB_RT;
        alucontrol_c = ALU_SUB;
        pcsrc_c      = PC_ALUOUT;
        pcwrite_c    = ~ctrl.zero;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      mem_req_c  = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      pcwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      illegal_c  = 1'b0;
    end
  end

  assign ctrl.mem_req    = mem_req_c;
  assign ctrl.iord       = iord_c;
  assign ctrl.memwrite   = memwrite_c;
  assign ctrl.irwrite    = irwrite_c;
  assign ctrl.pcwrite    = pcwrite_c;
  assign ctrl.memtoreg   = memtoreg_c;
  assign ctrl.regdst     = regdst_c;
  assign ctrl.regwrite   = regwrite_c;
  assign ctrl.alusrca    = alusrca_c;
  assign ctrl.alusrcb    = alusrcb_c;
  assign ctrl.pcsrc      = pcsrc_c;
  assign ctrl.alucontrol = alucontrol_c;
  assign ctrl.illegal    = illegal_c;
  assign ctrl.state      = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus randomized instruction
// streams checked against a path/table model of the control sequence.
module tb_mc_controller;
  localparam int unsigned OPW = 6;
  localparam int unsigned ACW = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   exp_path[$];

  always #5 clk = ~clk;

  mc_controller_if #(.OPW(OPW), .ACW(ACW)) bus ();
  mc_controller #(.OPW(OPW), .ACW(ACW)) dut (.clk(clk), .reset(reset), .ctrl(bus));

  // Observed outputs packed as {mem_req,iord,memwrite,irwrite,pcwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  function automatic logic [16:0] obs();
    return {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcwrite, bus.memtoreg,
            bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
            bus.illegal};
  endfunction

  function automatic bit bne_enabled();
`ifdef MC_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // ALU op for an R-type funct, or -1 if the funct is not recognised
  function automatic int funct_alu(logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  // State sequence an instruction walks through, ignoring memory waits
  function automatic void build_path(logic [5:0] op, logic [5:0] fn);
    exp_path.delete();
    exp_path.push_back(0);
    exp_path.push_back(1);
    if (op == OP_LW) begin
      exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4);
    end else if (op == OP_SW) begin
      exp_path.push_back(2); exp_path.push_back(5);
    end else if (op == OP_R) begin
      exp_path.push_back(6);
      if (funct_alu(fn) >= 0) exp_path.push_back(7);
    end else if (op == OP_BEQ) begin
      exp_path.push_back(8);
    end else if (op == OP_ADDI) begin
      exp_path.push_back(9); exp_path.push_back(10);
    end else if (op == OP_J) begin
      exp_path.push_back(11);
    end else if (op == OP_BNE && bne_enabled()) begin
      exp_path.push_back(12);
    end
  endfunction

  function automatic bit op_known(logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J) || (op == OP_BNE && bne_enabled());
  endfunction

  // Output table per state from the control description
  function automatic logic [16:0] spec_out(int st, logic rdy, logic z, logic [5:0] op, logic [5:0] fn);
    logic mreq, io, mw, irw, pcw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    int a;
    {mreq, io, mw, irw, pcw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (st)
      0:  begin mreq = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; alu = 3'b010; ill = !op_known(op); end
      2:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
      3:  begin mreq = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mreq = 1; io = 1; mw = 1; end
      6:  begin
            sa = 1; a = funct_alu(fn);
            if (a < 0) begin alu = 3'b010; ill = 1; end else alu = 3'(a);
          end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pcw = z; end
      9:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
      10: begin rw = 1; end
      11: begin ps = 2'b10; pcw = 1; end
      12: if (bne_enabled()) begin sa = 1; alu = 3'b110; ps = 2'b01; pcw = !z; end
      default: ;
    endcase
    return {mreq, io, mw, irw, pcw, m2r, rd, rw, sa, sb, ps, alu, ill};
  endfunction

  // zmode: -1 random zero each cycle, else the fixed zero value; stalls only in FETCH/MEMRD/MEMWR
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit rand_rdy, input int zmode);
    int idx = 0;
    int cyc = 0;
    logic rdy, z;
    logic [16:0] want;
    build_path(op, fn);
    bus.op = op;
    bus.funct = fn;
    while (idx < exp_path.size()) begin
      rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.mem_ready = rdy;
      bus.zero = z;
      @(negedge clk);
      want = spec_out(exp_path[idx], rdy, z, op, fn);
      checks++;
      if (bus.state !== 4'(exp_path[idx])) begin
        failures++;
        $display("FAIL instr_state op=%b fn=%b step=%0d got=%0d want=%0d", op, fn, idx, bus.state, exp_path[idx]);
      end
      checks++;
      if (obs() !== want) begin
        failures++;
        $display("FAIL instr_outputs op=%b fn=%b st=%0d rdy=%b z=%b got=%h want=%h", op, fn, exp_path[idx], rdy, z, obs(), want);
      end
      checks++;
      if ($countones({bus.regwrite, bus.memwrite, bus.irwrite}) > 1) begin
        failures++;
        $display("FAIL write_exclusive st=%0d got=%b want=at_most_one", bus.state, {bus.regwrite, bus.memwrite, bus.irwrite});
      end
      if (!((exp_path[idx] == 0 || exp_path[idx] == 3 || exp_path[idx] == 5) && !rdy)) idx++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        checks++; failures++;
        $display("FAIL instr_timeout op=%b got=%0d cycles want=<200", op, cyc);
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.op = OP_LW; bus.funct = FN_ADD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    checks++;
    if ({bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.mem_req, bus.illegal} !== 6'b0) begin
      failures++;
      $display("FAIL reset_enables got=%b want=000000", {bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.mem_req, bus.illegal});
    end
    checks++;
    if ({bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol} !== {1'b0, 1'b0, 2'b01, 2'b00, 3'b010}) begin
      failures++;
      $display("FAIL reset_selects got=%b want=%b", {bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol}, {1'b0, 1'b0, 2'b01, 2'b00, 3'b010});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.irwrite, bus.pcwrite, bus.mem_req} !== 3'b111) begin
      failures++;
      $display("FAIL post_reset_fetch got=%b want=111", {bus.irwrite, bus.pcwrite, bus.mem_req});
    end
    do_reset();
  endtask

  task automatic test_latency();
    logic [5:0] ops[6];
    int want[6];
    int n;
    ops[0] = OP_LW;   want[0] = 5;
    ops[1] = OP_SW;   want[1] = 4;
    ops[2] = OP_R;    want[2] = 4;
    ops[3] = OP_ADDI; want[3] = 4;
    ops[4] = OP_BEQ;  want[4] = 3;
    ops[5] = OP_J;    want[5] = 3;
    bus.mem_ready = 1'b1; bus.zero = 1'b0; bus.funct = FN_ADD;
    for (int i = 0; i < 6; i++) begin
      bus.op = ops[i];
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (bus.state !== 4'd0 && n < 32);
      checks++;
      if (n != want[i]) begin
        failures++;
        $display("FAIL latency op=%b got=%0d want=%0d", ops[i], n, want[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    int n = 0;
    bus.op = OP_LW; bus.funct = FN_ADD; bus.zero = 1'b0;
    do begin
      bus.mem_ready = (n >= 3 && n <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (n >= 3 && n <= 6) begin
        checks++;
        if ({bus.state, bus.mem_req, bus.iord} !== {4'd3, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL lw_wait_memrd cyc=%0d got=%b want=%b", n, {bus.state, bus.mem_req, bus.iord}, {4'd3, 1'b1, 1'b1});
        end
      end
      @(posedge clk); #1;
      n++;
    end while (bus.state !== 4'd0 && n < 32);
    checks++;
    if (n != 8) begin failures++; $display("FAIL lw_wait_total got=%0d want=8", n); end
  endtask

  task automatic test_branch_jump();
    run_instr(OP_R, FN_SUB, 1'b0, 0);
    run_instr(OP_R, 6'b111111, 1'b0, 0);
    run_instr(OP_BEQ, FN_ADD, 1'b0, 1);
    run_instr(OP_BEQ, FN_ADD, 1'b0, 0);
    run_instr(OP_J, FN_ADD, 1'b0, 0);
    run_instr(OP_BNE, FN_ADD, 1'b0, 0);
    run_instr(OP_BNE, FN_ADD, 1'b0, 1);
    run_instr(6'b111111, FN_ADD, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    int sel;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 8);
      fn = FN_ADD;
      case (sel)
        0: op = OP_LW;
        1: op = OP_SW;
        2: begin
             op = OP_R;
             case ($urandom_range(0, 4))
               0: fn = 6'b100000;
               1: fn = 6'b100010;
               2: fn = 6'b100100;
               3: fn = 6'b100101;
               default: fn = 6'b101010;
             endcase
           end
        3: begin op = OP_R; fn = 6'($urandom_range(0, 63)); end
        4: op = OP_BEQ;
        5: op = OP_ADDI;
        6: op = OP_J;
        7: op = OP_BNE;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, 1'b1, -1);
    end
  endtask

  task automatic test_reset_in_memwr();
    bus.op = OP_SW; bus.funct = FN_ADD; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.memwrite} !== {4'd5, 1'b1}) begin
      failures++;
      $display("FAIL memwr_hold got=%b want=%b", {bus.state, bus.memwrite}, {4'd5, 1'b1});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.memwrite, bus.mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL memwr_reset_strobe got=%b want=00", {bus.memwrite, bus.mem_req});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.state !== 4'd0) begin failures++; $display("FAIL memwr_reset_state got=%0d want=0", bus.state); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_lw_wait();
    test_branch_jump();
    test_random();
    test_reset_in_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
